axis_reg_slice: RTL and testbench
=================================

# axis_reg_slice

Parametrised AXI-Stream register slice: a chain of NUM_STAGES pipeline stages between a slave and a master stream port. It breaks timing paths on both the forward (tdata/tvalid and sideband) and backward (tready) directions. It extends the plain interface pass-through with tlast, selectable stage style and configurable depth. It is inserted at partition boundaries, and anywhere a stream crosses long routing, without changing stream content or ordering.

## Interface
- AXI_DATA_WIDTH, 64, tdata width; multiple of 8; tkeep width is AXI_DATA_WIDTH/8
- AXI_ID_WIDTH, 1, tid width
- AXI_DEST_WIDTH, 1, tdest width
- AXI_USER_WIDTH, 1, tuser width
- NUM_STAGES, 1, number of register stages, 0..8; 0 = combinational pass-through
- MODE, "FULL", "FULL" = skid-buffer stage at 1 beat/cycle; "LIGHT" = single-register stage at 1 beat per 2 cycles
- aclk  in  1  clock
- areset  in  1  asynchronous, active-high reset
- s_axis_tdata/tkeep/tid/tdest/tuser/tlast/tvalid  in  per parameter (tlast, tvalid: 1)  slave stream
- s_axis_tready  out  1  slave ready
- m_axis_tdata/tkeep/tid/tdest/tuser/tlast/tvalid  out  per parameter  master stream
- m_axis_tready  in  1  master ready

## Operation
- Payload = {tdata, tkeep, tid, tdest, tuser, tlast}, carried as one bundle. No field is altered, dropped or reordered.
- Beat transfer on a port: tvalid & tready at a rising aclk edge.
- Stages are chained: stage i master feeds stage i+1 slave.
- FULL stage: main register plus skid register.
  - Stage ready output is a registered bit equal to !skid_valid.
  - Accept with main empty, or main draining this edge: beat goes to main.
  - Accept with main full and not draining: beat goes to skid; ready drops next cycle.
  - Main drains and skid is full: skid moves to main, and ready returns high next cycle.
  - No combinational path from m_axis_tready to s_axis_tready.
- LIGHT stage: one register.
  - Ready = !valid, taken from the register output.
  - Accept sets valid; output transfer clears valid. Accept and clear never coincide.
- NUM_STAGES = 0: all m_axis_* driven directly from s_axis_*; s_axis_tready = m_axis_tready; areset has no effect.
- A master-side tvalid, once asserted, holds with stable payload until the transfer. This is an AXI-Stream rule and the block must satisfy it.
- Payload registers load only on accept, so they hold while stalled.

## Timing
- Reset values (NUM_STAGES ≥ 1): all stage valids 0, m_axis_tvalid = 0, s_axis_tready = 0.
  - Payload registers are don't-care.
  - FULL: ready registers go to 1 at the first aclk edge after areset deasserts.
  - LIGHT: s_axis_tready = 1 in the first cycle after deassertion, since it is derived from valid = 0.
- Reset mid-operation: all in-flight beats are discarded and m_axis_tvalid drops immediately (asynchronous). Recovery is as from power-up.
- Latency: a beat accepted at edge k is presented on m_axis_tvalid after edge k + NUM_STAGES − 1, i.e. visible in cycle k+NUM_STAGES, when unstalled.
- Throughput:
  - FULL: 1 beat/cycle sustained.
  - LIGHT: 1 beat per 2 cycles per stage boundary.
- Buffering capacity when m_axis_tready is held low:
  - FULL: 2×NUM_STAGES beats.
  - LIGHT: NUM_STAGES beats.
  - s_axis_tready must be 0 once capacity is reached.
- Simultaneous events: a FULL stage with main full, skid empty, input accept and output drain at the same edge puts the new beat into main; skid stays empty and ready stays 1.

## Test plan
- Reset, NUM_STAGES=3 FULL: assert areset for 5 cycles → m_axis_tvalid=0 throughout; s_axis_tready=0 during reset and 1 from the first edge after release.
- Streaming, FULL, NUM_STAGES=2: 100 back-to-back beats with incrementing tdata, tlast on every 10th, m_axis_tready=1.
  - First output in cycle 2 after first accept.
  - 100 beats in 100 consecutive cycles.
  - Payload and tlast bit-exact.
- Backpressure, FULL, NUM_STAGES=2: hold m_axis_tready=0 while streaming → exactly 4 beats accepted, then s_axis_tready=0. Release → all beats emerge in order, no loss or duplication.
- LIGHT, NUM_STAGES=1, continuous source and sink: s_axis_tready toggles 1,0,1,0; 50 beats take 100 cycles; output stable while stalled.
- NUM_STAGES=0 with random tvalid/tready: m_axis outputs equal s_axis inputs in the same cycle, s_axis_tready equals m_axis_tready, and areset pulses have no effect.
- Random valid/ready (70%/60%), FULL, NUM_STAGES=4, 10k beats with random tkeep/tid/tdest/tuser.
  - Scoreboard matches every field.
  - Inject one areset mid-stream → m_axis_tvalid=0 immediately, and no stale beat appears after reset.

Source files
------------

// File: rtl/axis_reg_slice_if.sv
// axis_reg_slice_if: AXI-Stream bundle shared by both sides of the register slice.
//
// Signals
//   tdata  [AXI_DATA_WIDTH]    payload data
//   tkeep  [AXI_DATA_WIDTH/8]  byte qualifiers
//   tid    [AXI_ID_WIDTH]      stream id
//   tdest  [AXI_DEST_WIDTH]    routing destination
//   tuser  [AXI_USER_WIDTH]    user sideband
//   tlast                      packet boundary
//   tvalid / tready            handshake
//
// Modports
//   master : drives payload and tvalid, receives tready
//   slave  : receives payload and tvalid, drives tready
interface axis_reg_slice_if #(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 1,
  parameter int AXI_DEST_WIDTH = 1,
  parameter int AXI_USER_WIDTH = 1
);
  logic [AXI_DATA_WIDTH-1:0]   tdata;
  logic [AXI_DATA_WIDTH/8-1:0] tkeep;
  logic [AXI_ID_WIDTH-1:0]     tid;
  logic [AXI_DEST_WIDTH-1:0]   tdest;
  logic [AXI_USER_WIDTH-1:0]   tuser;
  logic                        tlast;
  logic                        tvalid;
  logic                        tready;

  modport master (
    output tdata, tkeep, tid, tdest, tuser, tlast, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tid, tdest, tuser, tlast, tvalid,
    output tready
  );
endinterface

// File: rtl/axis_reg_slice.sv
// axis_reg_slice: chain of NUM_STAGES AXI-Stream register stages that cuts
// both the forward (payload/tvalid) and backward (tready) timing paths
// without altering stream content or ordering.
//
// Ports
//   aclk    in   clock
//   areset  in   asynchronous active-high reset (clears all stage valids)
//   s_axis  slave modport   upstream stream (s_axis.tready is an output)
//   m_axis  master modport  downstream stream (m_axis.tready is an input)
//
// MODE "FULL"  : main + skid register per stage, 1 beat/cycle, 2 beats deep.
// MODE "LIGHT" : single register per stage, 1 beat per 2 cycles, 1 beat deep.
// NUM_STAGES 0 : pure wires, reset unused.
module axis_reg_slice #(
  parameter int    AXI_DATA_WIDTH = 64,
  parameter int    AXI_ID_WIDTH   = 1,
  parameter int    AXI_DEST_WIDTH = 1,
  parameter int    AXI_USER_WIDTH = 1,
  parameter int    NUM_STAGES     = 1,
  parameter string MODE           = "FULL"
) (
  input logic              aclk,
  input logic              areset,
  axis_reg_slice_if.slave  s_axis,
  axis_reg_slice_if.master m_axis
);
  localparam int KW = AXI_DATA_WIDTH / 8;
  localparam int PW = AXI_DATA_WIDTH + KW + AXI_ID_WIDTH + AXI_DEST_WIDTH + AXI_USER_WIDTH + 1;

  if (NUM_STAGES == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = aclk | areset;

    assign m_axis.tdata  = s_axis.tdata;
    assign m_axis.tkeep  = s_axis.tkeep;
    assign m_axis.tid    = s_axis.tid;
    assign m_axis.tdest  = s_axis.tdest;
    assign m_axis.tuser  = s_axis.tuser;
    assign m_axis.tlast  = s_axis.tlast;
    assign m_axis.tvalid = s_axis.tvalid;
    assign s_axis.tready = m_axis.tready;
  end else begin : g_pipe
    // Element i is the slave side of stage i; element NUM_STAGES is the output.
    logic [NUM_STAGES:0] chain_valid;
    logic [NUM_STAGES:0] chain_ready;
    logic [PW-1:0]       chain_data [NUM_STAGES+1];

    assign chain_data[0]  = {s_axis.tdata, s_axis.tkeep, s_axis.tid,
                             s_axis.tdest, s_axis.tuser, s_axis.tlast};
    assign chain_valid[0] = s_axis.tvalid;
    assign s_axis.tready  = chain_ready[0];

    assign {m_axis.tdata, m_axis.tkeep, m_axis.tid,
            m_axis.tdest, m_axis.tuser, m_axis.tlast} = chain_data[NUM_STAGES];
    assign m_axis.tvalid           = chain_valid[NUM_STAGES];
    assign chain_ready[NUM_STAGES] = m_axis.tready;

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
      if (MODE == "LIGHT") begin : g_light
        logic          valid_q, valid_d;
        logic [PW-1:0] data_q, data_d;

        // Held low during reset so the port reads "not ready" until release.
        assign chain_ready[i]   = ~valid_q & ~areset;
        assign chain_valid[i+1] = valid_q;
        assign chain_data[i+1]  = data_q;

        // Empty -> can only fill; full -> can only drain, so the two never meet.
        always_comb begin
          valid_d = valid_q;
          data_d  = data_q;
          if (!valid_q && chain_valid[i]) begin
            valid_d = 1'b1;
            data_d  = chain_data[i];
          end else if (valid_q && chain_ready[i+1]) begin
            valid_d = 1'b0;
          end
        end

        always_ff @(posedge aclk or posedge areset) begin
          if (areset) valid_q <= 1'b0;
          else        valid_q <= valid_d;
        end

        always_ff @(posedge aclk) begin
          data_q <= data_d;
        end
      end else begin : g_full
        logic          main_valid_q, main_valid_d;
        logic          skid_valid_q, skid_valid_d;
        logic          ready_q;
        logic [PW-1:0] main_data_q, main_data_d;
        logic [PW-1:0] skid_data_q, skid_data_d;
        logic          in_fire;
        logic          main_free;

        assign chain_ready[i]   = ready_q;
        assign chain_valid[i+1] = main_valid_q;
        assign chain_data[i+1]  = main_data_q;

        assign in_fire   = chain_valid[i] & ready_q;
        // Main can take a beat this edge if it is empty or being drained.
        assign main_free = ~main_valid_q | chain_ready[i+1];

        // ready_q is low whenever skid is full, so in_fire and a full skid
        // never coincide.
        always_comb begin
          main_valid_d = main_valid_q;
          main_data_d  = main_data_q;
          skid_valid_d = skid_valid_q;
          skid_data_d  = skid_data_q;
          if (main_free) begin
            if (skid_valid_q) begin
              main_valid_d = 1'b1;
              main_data_d  = skid_data_q;
              skid_valid_d = 1'b0;
            end else begin
              main_valid_d = in_fire;
              if (in_fire) main_data_d = chain_data[i];
            end
          end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = chain_data[i];
          end
        end

        always_ff @(posedge aclk or posedge areset) begin
          if (areset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b0;
          end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ~skid_valid_d;
          end
        end

        always_ff @(posedge aclk) begin
          main_data_q <= main_data_d;
          skid_data_q <= skid_data_d;
        end
      end
    end
  end
endmodule

// File: tb/tb_axis_reg_slice.sv
// tb_axis_reg_slice: self-checking bench for axis_reg_slice across FULL/LIGHT
// modes and depths 0, 1, 2 and 4, checked against a queue-based stream model.
module tb_axis_reg_slice;
  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_err = 0;

  axis_reg_slice_if f2_s ();
  axis_reg_slice_if f2_m ();
  axis_reg_slice_if l1_s ();
  axis_reg_slice_if l1_m ();
  axis_reg_slice_if p0_s ();
  axis_reg_slice_if p0_m ();
  axis_reg_slice_if #(.AXI_ID_WIDTH(4), .AXI_DEST_WIDTH(3), .AXI_USER_WIDTH(5)) f4_s ();
  axis_reg_slice_if #(.AXI_ID_WIDTH(4), .AXI_DEST_WIDTH(3), .AXI_USER_WIDTH(5)) f4_m ();

  axis_reg_slice #(.NUM_STAGES(2), .MODE("FULL")) u_f2 (
    .aclk(aclk), .areset(areset), .s_axis(f2_s), .m_axis(f2_m));
  axis_reg_slice #(.NUM_STAGES(1), .MODE("LIGHT")) u_l1 (
    .aclk(aclk), .areset(areset), .s_axis(l1_s), .m_axis(l1_m));
  axis_reg_slice #(.NUM_STAGES(0), .MODE("FULL")) u_p0 (
    .aclk(aclk), .areset(areset), .s_axis(p0_s), .m_axis(p0_m));
  axis_reg_slice #(.AXI_ID_WIDTH(4), .AXI_DEST_WIDTH(3), .AXI_USER_WIDTH(5),
                   .NUM_STAGES(4), .MODE("FULL")) u_f4 (
    .aclk(aclk), .areset(areset), .s_axis(f4_s), .m_axis(f4_m));

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  logic [127:0] q[$];
  logic [127:0] exp_pl, prev_pl, got_pl;
  int  sent, got, cyc, first_acc, first_out, last_out;
  bit  s_fire, m_fire, last_sfire, prev_stall, did_rst;
  logic [63:0] r_data;
  logic [7:0]  r_keep;
  logic        r_id, r_dest, r_user, r_last, r_valid, r_ready;

  initial begin
    f2_s.tvalid = 0; f2_s.tdata = '0; f2_s.tkeep = '0; f2_s.tid = '0; f2_s.tdest = '0; f2_s.tuser = '0; f2_s.tlast = 0; f2_m.tready = 0;
    l1_s.tvalid = 0; l1_s.tdata = '0; l1_s.tkeep = '0; l1_s.tid = '0; l1_s.tdest = '0; l1_s.tuser = '0; l1_s.tlast = 0; l1_m.tready = 0;
    p0_s.tvalid = 0; p0_s.tdata = '0; p0_s.tkeep = '0; p0_s.tid = '0; p0_s.tdest = '0; p0_s.tuser = '0; p0_s.tlast = 0; p0_m.tready = 0;
    f4_s.tvalid = 0; f4_s.tdata = '0; f4_s.tkeep = '0; f4_s.tid = '0; f4_s.tdest = '0; f4_s.tuser = '0; f4_s.tlast = 0; f4_m.tready = 0;

    // ---- reset behaviour
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("rst_f4_mvalid", 128'(f4_m.tvalid), 128'(0));
      chk("rst_f4_sready", 128'(f4_s.tready), 128'(0));
      chk("rst_l1_sready", 128'(l1_s.tready), 128'(0));
    end
    areset = 1'b0;
    #1;
    chk("rel_f4_sready_before_edge", 128'(f4_s.tready), 128'(0));
    chk("rel_l1_sready_first_cycle", 128'(l1_s.tready), 128'(1));
    tick();
    chk("rel_f4_sready_after_edge", 128'(f4_s.tready), 128'(1));
    chk("rel_f2_sready_after_edge", 128'(f2_s.tready), 128'(1));
    chk("rel_f4_mvalid", 128'(f4_m.tvalid), 128'(0));

    // ---- FULL x2 streaming, sink always ready
    sent = 0; got = 0; cyc = 0; first_acc = -1; first_out = -1; last_out = -1;
    q.delete();
    f2_m.tready = 1;
    while (got < 100 && cyc < 400) begin
      f2_s.tvalid = (sent < 100);
      f2_s.tdata  = 64'(sent);
      f2_s.tkeep  = 8'hFF;
      f2_s.tlast  = (sent % 10 == 9);
      #1;
      s_fire = f2_s.tvalid & f2_s.tready;
      m_fire = f2_m.tvalid & f2_m.tready;
      if (f2_m.tvalid && first_out < 0) first_out = cyc;
      if (s_fire) begin
        if (first_acc < 0) first_acc = cyc;
        q.push_back(128'({64'(sent), 8'hFF, 1'b0, 1'b0, 1'b0, (sent % 10 == 9)}));
        sent++;
      end
      if (m_fire) begin
        got_pl = 128'({f2_m.tdata, f2_m.tkeep, f2_m.tid, f2_m.tdest, f2_m.tuser, f2_m.tlast});
        if (q.size() == 0) chk("stream_extra_beat", got_pl, 128'(0));
        else chk("stream_beat", got_pl, q.pop_front());
        got++;
        last_out = cyc;
      end
      tick();
      cyc++;
    end
    f2_s.tvalid = 0;
    chk("stream_count", 128'(got), 128'(100));
    chk("stream_latency", 128'(first_out - first_acc), 128'(2));
    chk("stream_span", 128'(last_out - first_out), 128'(99));

    // ---- FULL x2 backpressure: capacity 4
    sent = 0; got = 0; q.delete();
    f2_m.tready = 0;
    for (int c = 0; c < 20; c++) begin
      f2_s.tvalid = (sent < 10);
      f2_s.tdata  = 64'(1000 + sent);
      f2_s.tlast  = sent[0];
      #1;
      if (f2_s.tvalid & f2_s.tready) begin
        q.push_back(128'({64'(1000 + sent), 8'hFF, 1'b0, 1'b0, 1'b0, sent[0]}));
        sent++;
      end
      chk("bp_no_output_transfer", 128'(f2_m.tvalid & f2_m.tready), 128'(0));
      tick();
    end
    chk("bp_accepted", 128'(sent), 128'(4));
    chk("bp_sready_low", 128'(f2_s.tready), 128'(0));
    f2_m.tready = 1;
    cyc = 0;
    while (got < 10 && cyc < 100) begin
      f2_s.tvalid = (sent < 10);
      f2_s.tdata  = 64'(1000 + sent);
      f2_s.tlast  = sent[0];
      #1;
      s_fire = f2_s.tvalid & f2_s.tready;
      m_fire = f2_m.tvalid & f2_m.tready;
      if (s_fire) begin
        q.push_back(128'({64'(1000 + sent), 8'hFF, 1'b0, 1'b0, 1'b0, sent[0]}));
        sent++;
      end
      if (m_fire) begin
        got_pl = 128'({f2_m.tdata, f2_m.tkeep, f2_m.tid, f2_m.tdest, f2_m.tuser, f2_m.tlast});
        if (q.size() == 0) chk("bp_extra_beat", got_pl, 128'(0));
        else chk("bp_beat", got_pl, q.pop_front());
        got++;
      end
      tick();
      cyc++;
    end
    f2_s.tvalid = 0;
    chk("bp_drained", 128'(got), 128'(10));
    #1;
    chk("bp_empty_after", 128'(f2_m.tvalid), 128'(0));
    tick();

    // ---- LIGHT x1: half rate, stable while stalled
    sent = 0; got = 0; cyc = 0; first_acc = -1; last_out = -1; q.delete();
    l1_m.tready = 1;
    while (got < 50 && cyc < 300) begin
      l1_s.tvalid = (sent < 50);
      l1_s.tdata  = 64'(2000 + sent);
      l1_s.tkeep  = 8'h0F;
      l1_s.tlast  = sent[0];
      #1;
      if (cyc < 4) chk("light_ready_pattern", 128'(l1_s.tready), 128'(cyc % 2 == 0));
      s_fire = l1_s.tvalid & l1_s.tready;
      m_fire = l1_m.tvalid & l1_m.tready;
      if (s_fire) begin
        if (first_acc < 0) first_acc = cyc;
        q.push_back(128'({64'(2000 + sent), 8'h0F, 1'b0, 1'b0, 1'b0, sent[0]}));
        sent++;
      end
      if (m_fire) begin
        got_pl = 128'({l1_m.tdata, l1_m.tkeep, l1_m.tid, l1_m.tdest, l1_m.tuser, l1_m.tlast});
        if (q.size() == 0) chk("light_extra_beat", got_pl, 128'(0));
        else chk("light_beat", got_pl, q.pop_front());
        got++;
        last_out = cyc;
      end
      tick();
      cyc++;
    end
    chk("light_count", 128'(got), 128'(50));
    chk("light_cycles", 128'(last_out - first_acc + 1), 128'(100));
    l1_m.tready = 0;
    l1_s.tvalid = 1;
    l1_s.tdata  = 64'hABCD_0123_4567_89EF;
    l1_s.tlast  = 1;
    #1;
    chk("light_ready_before_stall", 128'(l1_s.tready), 128'(1));
    tick();
    l1_s.tvalid = 0;
    exp_pl = 128'({64'hABCD_0123_4567_89EF, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1});
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("light_stall_valid", 128'(l1_m.tvalid), 128'(1));
      chk("light_stall_payload",
          128'({l1_m.tdata, l1_m.tkeep, l1_m.tid, l1_m.tdest, l1_m.tuser, l1_m.tlast}), exp_pl);
      chk("light_stall_sready", 128'(l1_s.tready), 128'(0));
      tick();
    end
    l1_m.tready = 1;
    tick();
    #1;
    chk("light_drained", 128'(l1_m.tvalid), 128'(0));
    tick();

    // ---- NUM_STAGES=0 pass-through with random handshakes and reset pulses
    for (int c = 0; c < 200; c++) begin
      r_data  = {$urandom(), $urandom()};
      r_keep  = 8'($urandom());
      r_id    = 1'($urandom()); r_dest = 1'($urandom()); r_user = 1'($urandom());
      r_last  = 1'($urandom()); r_valid = 1'($urandom()); r_ready = 1'($urandom());
      p0_s.tdata = r_data; p0_s.tkeep = r_keep; p0_s.tid = r_id; p0_s.tdest = r_dest;
      p0_s.tuser = r_user; p0_s.tlast = r_last; p0_s.tvalid = r_valid; p0_m.tready = r_ready;
      areset = ($urandom_range(0, 9) == 0);
      #1;
      chk("p0_forward",
          128'({p0_m.tvalid, p0_m.tdata, p0_m.tkeep, p0_m.tid, p0_m.tdest, p0_m.tuser, p0_m.tlast}),
          128'({r_valid, r_data, r_keep, r_id, r_dest, r_user, r_last}));
      chk("p0_ready", 128'(p0_s.tready), 128'(r_ready));
      tick();
    end
    areset = 0;
    p0_s.tvalid = 0;
    tick();
    tick();

    // ---- FULL x4 random traffic with mid-stream reset
    sent = 0; got = 0; cyc = 0; q.delete();
    last_sfire = 0; prev_stall = 0; did_rst = 0; prev_pl = '0;
    while (got < 10000 && cyc < 60000) begin
      if (!f4_s.tvalid || last_sfire) begin
        f4_s.tvalid = ($urandom_range(0, 99) < 70);
        f4_s.tdata  = {$urandom(), $urandom()};
        f4_s.tkeep  = 8'($urandom());
        f4_s.tid    = 4'($urandom());
        f4_s.tdest  = 3'($urandom());
        f4_s.tuser  = 5'($urandom());
        f4_s.tlast  = 1'($urandom());
      end
      f4_m.tready = ($urandom_range(0, 99) < 60);
      #1;
      got_pl = 128'({f4_m.tdata, f4_m.tkeep, f4_m.tid, f4_m.tdest, f4_m.tuser, f4_m.tlast});
      if (!did_rst && got >= 5000 && f4_m.tvalid) begin
        areset = 1;
        #1;
        chk("mid_rst_mvalid", 128'(f4_m.tvalid), 128'(0));
        chk("mid_rst_sready", 128'(f4_s.tready), 128'(0));
        q.delete();
        did_rst = 1;
        f4_s.tvalid = 0;
        last_sfire = 0;
        prev_stall = 0;
        tick();
        tick();
        areset = 0;
        cyc++;
        continue;
      end
      if (prev_stall) begin
        chk("rand_hold_valid", 128'(f4_m.tvalid), 128'(1));
        chk("rand_hold_payload", got_pl, prev_pl);
      end
      s_fire = f4_s.tvalid & f4_s.tready;
      m_fire = f4_m.tvalid & f4_m.tready;
      if (m_fire) begin
        if (q.size() == 0) chk("rand_extra_beat", got_pl, 128'(0));
        else chk("rand_beat", got_pl, q.pop_front());
        got++;
      end
      if (s_fire) begin
        q.push_back(128'({f4_s.tdata, f4_s.tkeep, f4_s.tid, f4_s.tdest, f4_s.tuser, f4_s.tlast}));
        sent++;
      end
      chk("rand_capacity", 128'(q.size() <= 8), 128'(1));
      prev_stall = f4_m.tvalid & ~f4_m.tready;
      prev_pl    = got_pl;
      last_sfire = s_fire;
      tick();
      cyc++;
    end
    chk("rand_count", 128'(got), 128'(10000));
    chk("rand_reset_injected", 128'(did_rst), 128'(1));
    f4_s.tvalid = 0;
    f4_m.tready = 1;
    cyc = 0;
    while (q.size() > 0 && cyc < 50) begin
      #1;
      if (f4_m.tvalid) begin
        chk("rand_tail_beat",
            128'({f4_m.tdata, f4_m.tkeep, f4_m.tid, f4_m.tdest, f4_m.tuser, f4_m.tlast}),
            q.pop_front());
      end
      tick();
      cyc++;
    end
    chk("rand_tail_left", 128'(q.size()), 128'(0));
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("rand_no_stale", 128'(f4_m.tvalid), 128'(0));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
